// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive path.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } rx_state_e;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   localparam int PRESC_8  = 8;
   localparam int PRESC_16 = 16;
   localparam int PRESC_32 = 32;

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample (edge) counter wrapping at edge_end, plus a data-bit counter stepped by bit_inc.
module uart_rx_edge_bit_cnt
   import uart_rx_pkg::*;
#(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clr,
   input  logic               en,
   input  logic               bit_inc,
   input  logic [PRESC_W-1:0] edge_end,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic [BIT_W-1:0]   bit_cnt,
   output logic               edge_last
);

   assign edge_last = (edge_cnt == edge_end);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (clr) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (en) begin
         edge_cnt <= edge_last ? '0 : edge_cnt + PRESC_W'(1);
         if (bit_inc) bit_cnt <= bit_cnt + BIT_W'(1);
      end
   end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller: start detect, bit sequencing, parity/stop checks, data_valid.
module uart_rx_ctrl
   import uart_rx_pkg::*;
#(
   parameter int WIDTH   = 8,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rx_in,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_typ,
   input  logic               sampled_bit,
   input  logic [WIDTH-1:0]   p_data,
   output logic [PRESC_W-1:0] edge_cnt,
   output logic               dat_samp_en,
   output logic               deser_en,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err
);

   localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   rx_state_e          state, next_state;
   logic [PRESC_W-1:0] presc_q, dec_pt, edge_end;
   logic               par_en_q, par_typ_q;
   logic [BIT_W-1:0]   bit_cnt;
   logic               edge_last, at_dec, last_bit, frame_start;
   logic               cnt_clr, bit_inc;

   // Decision point sits a little past mid-bit so the 3-sample majority has settled.
   assign dec_pt      = (presc_q >> 1) + PRESC_W'(2);
   assign edge_end    = presc_q - PRESC_W'(1);
   assign at_dec      = (edge_cnt == dec_pt);
   assign last_bit    = (bit_cnt == BIT_W'(WIDTH - 1));
   assign frame_start = (state == IDLE) && !rx_in;

   // Counters are held at zero in IDLE/DONE and cleared on the way into them,
   // so the first START cycle always sees edge_cnt = 0.
   assign cnt_clr = (state == IDLE) || (next_state == IDLE) || (next_state == DONE);
   assign bit_inc = (state == DATA) && edge_last && !last_bit;

   uart_rx_edge_bit_cnt #(
      .PRESC_W (PRESC_W),
      .BIT_W   (BIT_W)
   ) u_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .clr       (cnt_clr),
      .en        (dat_samp_en),
      .bit_inc   (bit_inc),
      .edge_end  (edge_end),
      .edge_cnt  (edge_cnt),
      .bit_cnt   (bit_cnt),
      .edge_last (edge_last)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_comb begin
      next_state  = state;
      dat_samp_en = 1'b0;
      deser_en    = 1'b0;
      data_valid  = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_in) next_state = START;
         end
         START: begin
            dat_samp_en = 1'b1;
            if (at_dec && sampled_bit) next_state = IDLE;
            else if (edge_last)        next_state = DATA;
         end
         DATA: begin
            dat_samp_en = 1'b1;
            deser_en    = at_dec;
            if (edge_last && last_bit) next_state = par_en_q ? PARITY : STOP;
         end
         PARITY: begin
            dat_samp_en = 1'b1;
            if (edge_last) next_state = STOP;
         end
         STOP: begin
            dat_samp_en = 1'b1;
            if (at_dec) next_state = DONE;
         end
         DONE: begin
            data_valid = ~par_err & ~stp_err;
            next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // Frame configuration is frozen for the whole frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         presc_q   <= PRESC_W'(PRESC_8);
         par_en_q  <= 1'b0;
         par_typ_q <= PAR_EVEN;
      end else if (frame_start) begin
         presc_q   <= prescale;
         par_en_q  <= par_en;
         par_typ_q <= par_typ;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_err <= 1'b0;
         stp_err <= 1'b0;
      end else if (frame_start) begin
         par_err <= 1'b0;
         stp_err <= 1'b0;
      end else if ((state == PARITY) && at_dec) begin
         par_err <= (sampled_bit != ((^p_data) ^ par_typ_q));
      end else if ((state == STOP) && at_dec) begin
         stp_err <= ~sampled_bit;
      end
   end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: drives serial frames, models sampler/deserializer, checks frame results.
module tb_uart_rx_ctrl;

   localparam int WIDTH   = 8;
   localparam int PRESC_W = 6;

   logic               clk      = 1'b0;
   logic               rst_n    = 1'b1;
   logic               rx_in    = 1'b1;
   logic               par_en   = 1'b0;
   logic               par_typ  = 1'b0;
   logic [PRESC_W-1:0] prescale = 6'd8;
   logic               sampled_bit;
   logic [WIDTH-1:0]   p_data   = '0;
   logic [PRESC_W-1:0] edge_cnt;
   logic               dat_samp_en, deser_en, data_valid, par_err, stp_err;

   int total = 0, bad = 0;
   int cyc = 0, de_cnt = 0, de_bad = 0, dv_cnt = 0, dv_cyc = -1, exp_d = 6;
   logic [WIDTH-1:0] dv_data = '0;

   uart_rx_ctrl #(.WIDTH(WIDTH), .PRESC_W(PRESC_W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_in       (rx_in),
      .prescale    (prescale),
      .par_en      (par_en),
      .par_typ     (par_typ),
      .sampled_bit (sampled_bit),
      .p_data      (p_data),
      .edge_cnt    (edge_cnt),
      .dat_samp_en (dat_samp_en),
      .deser_en    (deser_en),
      .data_valid  (data_valid),
      .par_err     (par_err),
      .stp_err     (stp_err)
   );

   always #5 clk = ~clk;

   // Ideal sampler on a clean line; deserializer shifts right, LSB first.
   assign sampled_bit = rx_in;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (deser_en) p_data <= {sampled_bit, p_data[WIDTH-1:1]};
   end

   always @(negedge clk) begin
      if (deser_en) begin
         de_cnt <= de_cnt + 1;
         if (int'(edge_cnt) != exp_d) de_bad <= de_bad + 1;
      end
      if (data_valid) begin
         dv_cnt  <= dv_cnt + 1;
         dv_cyc  <= cyc;
         dv_data <= p_data;
      end
   end

   task automatic cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // Cycle (in cyc units) at which data_valid is expected for a frame whose start bit began at fall.
   function automatic int dv_at(input int fall, input int p, input logic pe);
      return fall + 1 + (1 + WIDTH + int'(pe)) * p + p / 2 + 2 + 1;
   endfunction

   task automatic send_frame(input logic [WIDTH-1:0] d, input int p, input logic pe,
                             input logic pt, input logic par_flip, input logic stop_bit,
                             input int chg, output int fall);
      prescale = PRESC_W'(p);
      par_en   = pe;
      par_typ  = pt;
      exp_d    = p / 2 + 2;
      rx_in    = 1'b0;
      fall     = cyc;
      cycles(p);
      if (chg != 0) prescale = PRESC_W'(chg);
      for (int i = 0; i < WIDTH; i++) begin
         rx_in = d[i];
         cycles(p);
      end
      if (pe) begin
         rx_in = (^d) ^ pt ^ par_flip;
         cycles(p);
      end
      rx_in = stop_bit;
      cycles(p);
      rx_in = 1'b1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      cycles(3);
      total++;
      if ({edge_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err} !== '0) begin
         bad++;
         $display("FAIL reset_outputs got=%0h want=0",
                  {edge_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err});
      end
      rst_n = 1'b1;
      cycles(3);
      total++;
      if ({edge_cnt, dat_samp_en, deser_en, data_valid} !== '0) begin
         bad++;
         $display("FAIL idle_after_reset got=%0h want=0", {edge_cnt, dat_samp_en, deser_en, data_valid});
      end
   endtask

   task automatic test_basic;
      int fall, n_dv, n_de, n_bad;
      cycles(2);
      n_dv = dv_cnt; n_de = de_cnt; n_bad = de_bad;
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, fall);
      cycles(4);
      total++;
      if (dv_cnt - n_dv !== 1) begin bad++; $display("FAIL basic_dv_cnt got=%0d want=1", dv_cnt - n_dv); end
      total++;
      if (dv_cyc - (fall + 1) !== 79) begin bad++; $display("FAIL basic_latency got=%0d want=79", dv_cyc - (fall + 1)); end
      total++;
      if (dv_data !== 8'hA5) begin bad++; $display("FAIL basic_data got=%0h want=a5", dv_data); end
      total++;
      if (de_cnt - n_de !== 8) begin bad++; $display("FAIL basic_deser_cnt got=%0d want=8", de_cnt - n_de); end
      total++;
      if (de_bad - n_bad !== 0) begin bad++; $display("FAIL basic_deser_edge got=%0d off-point strobes want=0", de_bad - n_bad); end
   endtask

   task automatic test_parity;
      int fall, n_dv;
      cycles(2);
      n_dv = dv_cnt;
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b0, 1'b1, 0, fall);
      cycles(4);
      total++;
      if (dv_cnt - n_dv !== 1 || dv_data !== 8'h3C) begin
         bad++; $display("FAIL par_good got=%0d/%0h want=1/3c", dv_cnt - n_dv, dv_data);
      end
      total++;
      if (dv_cyc !== dv_at(fall, 8, 1'b1)) begin bad++; $display("FAIL par_latency got=%0d want=%0d", dv_cyc, dv_at(fall, 8, 1'b1)); end
      total++;
      if (par_err !== 1'b0) begin bad++; $display("FAIL par_good_flag got=%b want=0", par_err); end
      n_dv = dv_cnt;
      cycles(2);
      send_frame(8'h3C, 8, 1'b1, 1'b0, 1'b1, 1'b1, 0, fall);
      cycles(4);
      total++;
      if (par_err !== 1'b1) begin bad++; $display("FAIL par_bad_flag got=%b want=1", par_err); end
      total++;
      if (dv_cnt - n_dv !== 0) begin bad++; $display("FAIL par_bad_dv got=%0d want=0", dv_cnt - n_dv); end
   endtask

   task automatic test_glitch;
      int fall, n_dv, n_de;
      cycles(2);
      n_dv = dv_cnt; n_de = de_cnt;
      prescale = 6'd16; exp_d = 10;
      rx_in = 1'b0; fall = cyc;
      cycles(3);
      rx_in = 1'b1;
      cycles(2);
      total++;
      if (dat_samp_en !== 1'b1) begin bad++; $display("FAIL glitch_in_start got=%b want=1", dat_samp_en); end
      cycles(8);
      total++;
      if ({dat_samp_en, edge_cnt, par_err, stp_err} !== '0) begin
         bad++; $display("FAIL glitch_back_idle got=%0h want=0", {dat_samp_en, edge_cnt, par_err, stp_err});
      end
      cycles(20);
      total++;
      if (de_cnt - n_de !== 0 || dv_cnt - n_dv !== 0) begin
         bad++; $display("FAIL glitch_no_strobes got=%0d/%0d want=0/0", de_cnt - n_de, dv_cnt - n_dv);
      end
   endtask

   task automatic test_stop_err;
      int fall, n_dv;
      logic [WIDTH-1:0] d;
      cycles(2);
      n_dv = dv_cnt;
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b0, 0, fall);
      cycles(4);
      total++;
      if (stp_err !== 1'b1 || par_err !== 1'b0) begin
         bad++; $display("FAIL stop_err_flags got=%b%b want=10", stp_err, par_err);
      end
      total++;
      if (dv_cnt - n_dv !== 0) begin bad++; $display("FAIL stop_err_dv got=%0d want=0", dv_cnt - n_dv); end
      d = WIDTH'($urandom);
      n_dv = dv_cnt;
      cycles(3);
      send_frame(d, 8, 1'b0, 1'b0, 1'b0, 1'b1, 0, fall);
      cycles(4);
      total++;
      if (stp_err !== 1'b0 || dv_cnt - n_dv !== 1 || dv_data !== d) begin
         bad++; $display("FAIL stop_recover got=%b/%0d/%0h want=0/1/%0h", stp_err, dv_cnt - n_dv, dv_data, d);
      end
   endtask

   task automatic test_back_to_back;
      int fall, n_dv;
      cycles(2);
      n_dv = dv_cnt;
      send_frame(8'h01, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, fall);
      total++;
      if (dv_cnt - n_dv !== 1 || dv_data !== 8'h01 || dv_cyc !== dv_at(fall, 32, 1'b0)) begin
         bad++; $display("FAIL b2b_first got=%0d/%0h/%0d want=1/01/%0d", dv_cnt - n_dv, dv_data, dv_cyc, dv_at(fall, 32, 1'b0));
      end
      send_frame(8'hFE, 32, 1'b0, 1'b0, 1'b0, 1'b1, 0, fall);
      cycles(4);
      total++;
      if (dv_cnt - n_dv !== 2 || dv_data !== 8'hFE || dv_cyc !== dv_at(fall, 32, 1'b0)) begin
         bad++; $display("FAIL b2b_second got=%0d/%0h/%0d want=2/fe/%0d", dv_cnt - n_dv, dv_data, dv_cyc, dv_at(fall, 32, 1'b0));
      end
   endtask

   task automatic test_reset_mid;
      int fall, n_dv;
      logic [WIDTH-1:0] d;
      d = 8'h7E;
      cycles(2);
      n_dv = dv_cnt;
      prescale = 6'd8; par_en = 1'b0; exp_d = 6;
      rx_in = 1'b0;
      cycles(8);
      for (int i = 0; i < 4; i++) begin rx_in = d[i]; cycles(8); end
      rx_in = d[4];
      cycles(4);
      rst_n = 1'b0;
      #1;
      total++;
      if ({edge_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err} !== '0) begin
         bad++; $display("FAIL midreset_outputs got=%0h want=0",
                         {edge_cnt, dat_samp_en, deser_en, data_valid, par_err, stp_err});
      end
      rx_in = 1'b1;
      cycles(3);
      rst_n = 1'b1;
      cycles(3);
      total++;
      if (dv_cnt - n_dv !== 0 || dat_samp_en !== 1'b0) begin
         bad++; $display("FAIL midreset_abort got=%0d/%b want=0/0", dv_cnt - n_dv, dat_samp_en);
      end
      send_frame(d, 16, 1'b0, 1'b0, 1'b0, 1'b1, 32, fall);
      cycles(4);
      total++;
      if (dv_cnt - n_dv !== 1 || dv_data !== d || dv_cyc !== dv_at(fall, 16, 1'b0)) begin
         bad++; $display("FAIL midreset_next got=%0d/%0h/%0d want=1/7e/%0d", dv_cnt - n_dv, dv_data, dv_cyc, dv_at(fall, 16, 1'b0));
      end
   endtask

   task automatic test_random;
      int fall, n_dv, n_de, n_bad, p;
      logic [WIDTH-1:0] d;
      logic pe, pt, flip, stp, good;
      for (int k = 0; k < 8; k++) begin
         case ($urandom_range(0, 2))
            0:       p = 8;
            1:       p = 16;
            default: p = 32;
         endcase
         d    = WIDTH'($urandom);
         pe   = 1'($urandom_range(0, 1));
         pt   = 1'($urandom_range(0, 1));
         flip = pe && ($urandom_range(0, 3) == 0);
         // A bad stop bit is only followed by a clean idle line when P = 8.
         stp  = !((p == 8) && ($urandom_range(0, 3) == 0));
         good = !flip && stp;
         cycles(2 + $urandom_range(0, 3));
         n_dv = dv_cnt; n_de = de_cnt; n_bad = de_bad;
         send_frame(d, p, pe, pt, flip, stp, 0, fall);
         cycles(4);
         total++;
         if (par_err !== flip || stp_err !== !stp) begin
            bad++; $display("FAIL rand%0d_flags got=%b%b want=%b%b", k, par_err, stp_err, flip, !stp);
         end
         total++;
         if (dv_cnt - n_dv !== int'(good)) begin
            bad++; $display("FAIL rand%0d_dv got=%0d want=%0d", k, dv_cnt - n_dv, good);
         end
         total++;
         if (de_cnt - n_de !== WIDTH || de_bad - n_bad !== 0) begin
            bad++; $display("FAIL rand%0d_deser got=%0d/%0d want=8/0", k, de_cnt - n_de, de_bad - n_bad);
         end
         if (good) begin
            total++;
            if (dv_data !== d || dv_cyc !== dv_at(fall, p, pe)) begin
               bad++; $display("FAIL rand%0d_frame got=%0h@%0d want=%0h@%0d", k, dv_data, dv_cyc, d, dv_at(fall, p, pe));
            end
         end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_parity;
      test_glitch;
      test_stop_err;
      test_back_to_back;
      test_reset_mid;
      test_random;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
